rs_syndrome: RTL and testbench
==============================

Name: rs_syndrome

Overview:
Receive-side counterpart of the RS(255,239) encoder parity chain. It is the first stage of the RS decoder. It accepts one received 8-bit codeword symbol per valid cycle and evaluates the received polynomial at alpha^(FCR+i) for i = 0..NSYM-1 using Horner's rule. It outputs all NSYM syndromes plus a nonzero flag to the downstream key-equation solver.

Parameters:
- RS_N, 255: codeword length in symbols.
- RS_NSYM, 16: number of parity symbols, which is also the number of syndromes.
- GF_POLY, 9'h11D: field primitive polynomial x^8+x^4+x^3+x^2+1.
- FCR, 0: first consecutive root exponent. Generator roots are alpha^FCR .. alpha^(FCR+NSYM-1).

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: in_data carries a symbol this cycle.
- in_sop, input, 1: first symbol of a codeword. Qualified by in_valid.
- in_data, input, 8: received symbol, highest-degree coefficient (r_254) first.
- out_valid, output, 1: one-cycle pulse; synd and synd_nz are valid.
- synd, output, 8*RS_NSYM: S_i is held in bits [8i+7:8i].
- synd_nz, output, 1: OR of all syndromes, meaning an error was detected.
- sop_err, output, 1: one-cycle pulse when in_sop arrives before the current codeword completes.

Behaviour:
- Reset (rst=0 at clk edge): all outputs go to 0. State goes to IDLE, symbol counter to 0, accumulators to 0. A reset mid-codeword discards the partial codeword and produces no out_valid.
- States:
  - IDLE: in_valid=1 with in_sop=1 loads acc_i <= in_data for every i, sets cnt=1, and moves to ACCUM. in_valid without in_sop is ignored.
  - ACCUM:
    - in_valid=1, in_sop=0: acc_i <= gf_mul(acc_i, alpha^(FCR+i)) XOR in_data; cnt++.
    - in_valid=0: accumulators and cnt hold, so gaps of any length are allowed.
    - When the accepted symbol makes cnt reach RS_N: synd <= next acc values, synd_nz <= (next acc != 0), out_valid=1 on the following cycle, and state returns to IDLE.
  - Back-to-back codewords: in_sop on the cycle immediately after the last symbol is accepted normally from IDLE, with zero bubble.
- in_sop while in ACCUM, before cnt reaches RS_N:
  - pulse sop_err for one cycle;
  - restart accumulation with this symbol (acc_i <= in_data, cnt=1);
  - the aborted codeword produces no out_valid.
- Latency: out_valid is asserted one clk after the edge that captures the RS_N-th symbol.
- synd and synd_nz hold their values until the next out_valid. out_valid and sop_err are single-cycle pulses.
- Arithmetic: all operations are GF(2^8) modulo GF_POLY. Addition is XOR. Multiply-by-constant is a pure XOR network, and each accumulator has one registered stage per symbol.
- cnt is 8 bits wide and never wraps past RS_N.

Optional Feature:
- Macro: RS_SYND_ERRCNT_EN.
- Defined: adds output err_cnt [15:0].
  - Increments on each out_valid with synd_nz=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package rs_pkg holds:
  - constants RS_N, RS_NSYM, GF_POLY, FCR;
  - GF(2^8) typedef gf_t (8-bit);
  - function gf_alpha_pow(e);
  - generic function gf_mul for use in benches.
- Sub-module gf_const_mul:
  - parameter EXP, 8-bit input, 8-bit output, combinational;
  - multiplies by alpha^EXP;
  - instantiated RS_NSYM times with EXP = FCR+i.

Test Plan:
- All-zero codeword, 255 symbols of 8'h00 -> one out_valid; every S_i = 8'h00; synd_nz=0.
- Encoder output for message bytes 1..239 fed through -> all S_i = 0; synd_nz=0.
- Zero codeword except the last symbol = 8'h01 -> every S_i = 8'h01; synd_nz=1.
- Zero codeword except symbol 254 (second-to-last) = 8'h01 -> S_i = alpha^i: S0=01, S1=02, S7=80, S8=1D, S15=26.
- Random in_valid gaps (about 30% idle) on the single-error case -> syndromes identical to the gapless run. A second in_sop at symbol 100 -> sop_err pulse, syndromes reflect only the second codeword.
- Assert rst=0 at symbol 120, then send a clean codeword -> no out_valid for the aborted frame. The new frame gives all-zero syndromes. With RS_SYND_ERRCNT_EN defined, err_cnt=0 after reset, then 1 after one erroneous codeword.

Source files
------------

// File: rtl/rs_pkg.sv
// rs_pkg: RS(255,239) constants, FSM encoding and GF(2^8) helpers shared by the syndrome stage
package rs_pkg;
  localparam int RS_N = 255;
  localparam int RS_NSYM = 16;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int FCR = 0;
  typedef logic [7:0] gf_t;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction
  function automatic gf_t gf_alpha_pow(int e);
    gf_t p;
    p = 8'h01;
    for (int k = 0; k < e % 255; k++) p = gf_mul(p, 8'h02);
    return p;
  endfunction
endpackage

// File: rtl/gf_const_mul.sv
// gf_const_mul: combinational GF(2^8) multiply by the constant alpha^EXP
module gf_const_mul
  import rs_pkg::*;
#(
  parameter int EXP = 0
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam gf_t C = gf_alpha_pow(EXP);
  // constant operand folds gf_mul into a fixed XOR network
  assign o_y = gf_mul(i_a, C);
endmodule

// File: rtl/rs_syndrome.sv
// rs_syndrome: Horner-rule RS syndrome evaluator, one received symbol per valid cycle
// Optional macro RS_SYND_ERRCNT_EN adds err_cnt, a saturating count of erroneous codewords
module rs_syndrome
  import rs_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  output logic [8*RS_NSYM-1:0]   synd,
  output logic                   synd_nz,
  output logic                   sop_err
`ifdef RS_SYND_ERRCNT_EN
  ,
  output logic [15:0]            err_cnt
`endif
);
  state_t r_state, w_state_nx;
  logic [7:0] r_cnt;
  logic [8*RS_NSYM-1:0] r_acc, w_mul, w_acc_nx, r_synd;
  logic r_out_valid, r_synd_nz, r_sop_err;
  logic w_load, w_step, w_done, w_sop_err;
  for (genvar g = 0; g < RS_NSYM; g++) begin : g_mul
    gf_const_mul #(.EXP(FCR + g)) u_mul (.i_a(r_acc[8*g+:8]), .o_y(w_mul[8*g+:8]));
  end
  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_state_nx;
  always_comb w_state_nx = r_state == IDLE ? (w_load ? ACCUM : IDLE) : (w_done ? IDLE : ACCUM);
  // an in_sop seen in ACCUM always aborts: completion already returned to IDLE
  always_comb begin
    w_load = in_valid & in_sop;
    w_step = in_valid & ~in_sop & (r_state == ACCUM);
    w_done = w_step & (r_cnt == 8'(RS_N - 1));
    w_sop_err = w_load & (r_state == ACCUM);
    w_acc_nx = w_load ? {RS_NSYM{in_data}} : w_mul ^ {RS_NSYM{in_data}};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_synd <= '0;
      r_synd_nz <= 1'b0;
      r_out_valid <= 1'b0;
      r_sop_err <= 1'b0;
    end else begin
      r_out_valid <= w_done;
      r_sop_err <= w_sop_err;
      if (w_load || w_step) begin
        r_acc <= w_acc_nx;
        r_cnt <= w_load ? 8'd1 : r_cnt + 8'd1;
      end
      if (w_done) begin
        r_synd <= w_acc_nx;
        r_synd_nz <= |w_acc_nx;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign synd = r_synd;
  assign synd_nz = r_synd_nz;
  assign sop_err = r_sop_err;
`ifdef RS_SYND_ERRCNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (!rst) r_err_cnt <= '0;
    else if (w_done && (|w_acc_nx) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_rs_syndrome.sv
// tb_rs_syndrome: directed vectors against a polynomial-evaluation model of the syndrome stage
module tb_rs_syndrome;
  localparam int FCR = 0;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_sop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic out_valid, synd_nz, sop_err;
  logic [127:0] synd;
`ifdef RS_SYND_ERRCNT_EN
  logic [15:0] err_cnt;
`endif
  rs_syndrome dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .out_valid(out_valid), .synd(synd), .synd_nz(synd_nz), .sop_err(sop_err)
`ifdef RS_SYND_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_ov = 0, n_se = 0;
  int lg[256];
  logic [7:0] ex[510];
  logic [7:0] fr[255];
  logic [7:0] q[$];
  logic m_valid = 1'b0, m_sop = 1'b0, m_nz = 1'b0;
  logic [127:0] m_synd = '0;
  logic [15:0] m_err = '0;
  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    return (a == 8'h00 || b == 8'h00) ? 8'h00 : ex[lg[a] + lg[b]];
  endfunction
  // model: collect a frame's symbols, evaluate r(alpha^(FCR+i)) directly as a sum of terms
  initial begin
    logic [7:0] x, s;
    x = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = x;
      ex[k+255] = x;
      lg[x] = k;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    forever begin
      @(posedge clk);
      m_valid = 1'b0;
      m_sop = 1'b0;
      if (!rst) begin
        q.delete();
        m_synd = '0;
        m_nz = 1'b0;
        m_err = '0;
      end else if (in_valid) begin
        if (in_sop) begin
          m_sop = q.size() != 0;
          q.delete();
          q.push_back(in_data);
        end else if (q.size() != 0) q.push_back(in_data);
        if (q.size() == 255) begin
          for (int i = 0; i < 16; i++) begin
            s = 8'h00;
            for (int k = 0; k < 255; k++)
              if (q[k] != 8'h00) s = s ^ ex[(lg[q[k]] + ((FCR + i) * (254 - k)) % 255) % 255];
            m_synd[8*i+:8] = s;
          end
          m_nz = m_synd != '0;
          m_valid = 1'b1;
          if (m_nz && m_err != 16'hFFFF) m_err = m_err + 16'd1;
          q.delete();
        end
      end
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      chk("sop_err", 128'(sop_err), 128'(m_sop));
      chk("synd", synd, m_synd);
      chk("synd_nz", 128'(synd_nz), 128'(m_nz));
`ifdef RS_SYND_ERRCNT_EN
      chk("err_cnt", 128'(err_cnt), 128'(m_err));
`endif
      if (out_valid) n_ov++;
      if (sop_err) n_se++;
    end
  end
  task automatic send(int n, int gap);
    for (int k = 0; k < n; k++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_sop = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_sop = k == 0;
      in_data = fr[k];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sop = 1'b0;
  endtask
  task automatic zero_fr();
    for (int k = 0; k < 255; k++) fr[k] = 8'h00;
  endtask
  task automatic build_enc();
    logic [7:0] g[17];
    logic [7:0] r[16];
    logic [7:0] fb;
    for (int j = 0; j < 17; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j >= 0; j--)
        if (j > 0) g[j] = g[j-1] ^ gm(g[j], ex[FCR+i]);
        else g[0] = gm(g[0], ex[FCR+i]);
    for (int j = 0; j < 16; j++) r[j] = 8'h00;
    for (int k = 0; k < 239; k++) begin
      fr[k] = 8'(k + 1);
      fb = fr[k] ^ r[15];
      for (int j = 15; j > 0; j--) r[j] = r[j-1] ^ gm(fb, g[j]);
      r[0] = gm(fb, g[0]);
    end
    for (int j = 0; j < 16; j++) fr[239+j] = r[15-j];
  endtask
  task automatic chk_alpha(string tag);
    chk({tag, "_S0"}, 128'(synd[7:0]), 128'h01);
    chk({tag, "_S1"}, 128'(synd[15:8]), 128'h02);
    chk({tag, "_S7"}, 128'(synd[63:56]), 128'h80);
    chk({tag, "_S8"}, 128'(synd[71:64]), 128'h1D);
    chk({tag, "_S15"}, 128'(synd[127:120]), 128'h26);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_synd", synd, 128'h0);
    chk("rst_ov", 128'(out_valid), 128'h0);
    rst = 1'b1;
    zero_fr();
    send(255, 0);
    chk("zero_ov", 128'(out_valid), 128'h1);
    chk("zero_synd", synd, 128'h0);
    chk("zero_nz", 128'(synd_nz), 128'h0);
    build_enc();
    send(255, 0);
    chk("enc_ov", 128'(out_valid), 128'h1);
    chk("enc_synd", synd, 128'h0);
    chk("enc_nz", 128'(synd_nz), 128'h0);
    zero_fr();
    fr[254] = 8'h01;
    send(255, 0);
    chk("last1_synd", synd, {16{8'h01}});
    chk("last1_nz", 128'(synd_nz), 128'h1);
    zero_fr();
    fr[253] = 8'h01;
    send(255, 0);
    chk_alpha("r1");
    chk("model_S8", 128'(m_synd[71:64]), 128'h1D);
    chk("model_S15", 128'(m_synd[127:120]), 128'h26);
    send(255, 30);
    chk_alpha("gap");
    for (int k = 0; k < 100; k++) fr[k] = 8'(k * 7 + 3);
    send(100, 0);
    zero_fr();
    fr[253] = 8'h01;
    send(255, 0);
    chk_alpha("resop");
    for (int k = 0; k < 120; k++) fr[k] = 8'(k + 9);
    send(120, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
`ifdef RS_SYND_ERRCNT_EN
    chk("errcnt_rst", 128'(err_cnt), 128'h0);
`endif
    build_enc();
    send(255, 0);
    chk("post_rst_synd", synd, 128'h0);
    chk("post_rst_nz", 128'(synd_nz), 128'h0);
    zero_fr();
    fr[254] = 8'h01;
    send(255, 0);
    chk("err_nz", 128'(synd_nz), 128'h1);
`ifdef RS_SYND_ERRCNT_EN
    chk("errcnt_one", 128'(err_cnt), 128'h1);
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("n_out_valid", 128'(n_ov), 128'd8);
    chk("n_sop_err", 128'(n_se), 128'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
